// File: rtl/elevator_pkg.sv
// Shared types and helpers for the single-car elevator scheduler.
// State encoding, default sizing and the "requests above/below a floor" queries.
package elevator_pkg;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

   localparam int NUM_FLOORS_DEF = 5;
   localparam int FLOOR_W_DEF    = 3;
   localparam int MAX_FLOORS     = 32;
   localparam int CNT_W          = 16;

   // Request vectors are zero-extended to a fixed width so one helper serves any car size.
   typedef logic [MAX_FLOORS-1:0] floor_vec_t;

   function automatic logic any_above(floor_vec_t vec, int floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (i > floor && vec[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic any_below(floor_vec_t vec, int floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (i < floor && vec[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Button inputs and car status outputs of the elevator scheduler.
// master = scheduler side, slave = button panel / display side.
interface elevator_scheduler_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int FLOOR_W    = FLOOR_W_DEF
);
   logic [NUM_FLOORS-1:0] buttons;
   logic [FLOOR_W-1:0]    current_floor;
   logic                  door_open;
   logic                  moving;
   logic                  dir_up;
   logic [NUM_FLOORS-1:0] pending;

   modport master (input buttons, output current_floor, door_open, moving, dir_up, pending);
   modport slave  (output buttons, input current_floor, door_open, moving, dir_up, pending);
endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter that parks at zero; zero flags the expiry of an interval.
module elevator_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)                  count_reg <= '0;
      else if (load)            count_reg <= value;
      else if (count_reg != '0) count_reg <= count_reg - 1'b1;
   end

   assign zero = (count_reg == '0);
endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy request scheduler and motion sequencer for one elevator car.
// Optional idle parking to floor 0 is built when ELEV_PARK_EN is defined.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
   parameter int FLOOR_W       = FLOOR_W_DEF,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
`ifdef ELEV_PARK_EN
  ,parameter int PARK_CYCLES   = 16
`endif
) (
   input logic                  clk,
   input logic                  rst,
   elevator_scheduler_if.master bus
);
   state_t                   state_reg;
   logic [FLOOR_W-1:0]       floor_reg, next_floor, open_floor;
   logic                     door_reg, moving_reg, dir_up_reg;
   logic [NUM_FLOORS-1:0]    pending_reg, clr;
   logic [2**FLOOR_W-1:0]    pend_full;
   floor_vec_t               pend_ext;
   logic                     is_move, here_req, step_here_req, btn_here;
   logic                     up_cur, dn_cur, up_nf, dn_nf, ahead_nf, behind_nf;
   logic                     open_en, door_bound, tmr_load, tmr_zero;
   logic                     park_go, park_hold;
   logic [CNT_W-1:0]         tmr_value;

   always_comb begin
      pend_full = '0;
      pend_full[NUM_FLOORS-1:0] = pending_reg;
      pend_ext = '0;
      pend_ext[NUM_FLOORS-1:0] = pending_reg;
   end

   assign is_move       = (state_reg == MOVE_UP) || (state_reg == MOVE_DOWN);
   assign next_floor    = (state_reg == MOVE_UP) ? floor_reg + 1'b1 : floor_reg - 1'b1;
   assign here_req      = pend_full[floor_reg];
   assign step_here_req = pend_full[next_floor];
   assign btn_here      = bus.buttons[floor_reg];
   assign up_cur        = any_above(pend_ext, int'(floor_reg));
   assign dn_cur        = any_below(pend_ext, int'(floor_reg));
   assign up_nf         = any_above(pend_ext, int'(next_floor));
   assign dn_nf         = any_below(pend_ext, int'(next_floor));
   assign ahead_nf      = (state_reg == MOVE_UP) ? up_nf : dn_nf;
   assign behind_nf     = (state_reg == MOVE_UP) ? dn_nf : up_nf;

   // The floor whose request is cleared this edge; the door floor masks presses all dwell long.
   assign open_en    = (state_reg == IDLE && here_req) || (is_move && tmr_zero && step_here_req) ||
                       (state_reg == DOOR_OPEN);
   assign open_floor = is_move ? next_floor : floor_reg;

   for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_clr
      assign clr[gi] = open_en && (open_floor == FLOOR_W'(gi));
   end

   // One timer serves travel and dwell: it reloads at every decision point, value set by the
   // destination of that decision (IDLE reloads every cycle; the value only matters on exit).
   assign door_bound = (state_reg == IDLE && here_req) || (is_move && step_here_req) ||
                       (state_reg == DOOR_OPEN && btn_here);
   assign tmr_load   = (state_reg == IDLE) || tmr_zero || (state_reg == DOOR_OPEN && btn_here);
   assign tmr_value  = door_bound ? CNT_W'(DOOR_CYCLES - 1) : CNT_W'(TRAVEL_CYCLES - 1);

   elevator_timer #(.W(CNT_W)) u_motion_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

`ifdef ELEV_PARK_EN
   logic park_zero, parking_reg;

   elevator_timer #(.W(CNT_W)) u_park_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (state_reg != IDLE || pending_reg != '0),
      .value (CNT_W'(PARK_CYCLES - 1)),
      .zero  (park_zero)
   );

   assign park_go   = park_zero && (pending_reg == '0) && (floor_reg != '0);
   // A parking descent keeps going only while nothing at all is requested.
   assign park_hold = parking_reg && (pending_reg == '0) && (next_floor != '0);

   always_ff @(posedge clk) begin
      if (rst)                      parking_reg <= 1'b0;
      else if (state_reg == IDLE)   parking_reg <= park_go;
      else if (is_move && tmr_zero) parking_reg <= park_hold;
   end
`else
   assign park_go   = 1'b0;
   assign park_hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         floor_reg   <= '0;
         door_reg    <= 1'b0;
         moving_reg  <= 1'b0;
         dir_up_reg  <= 1'b1;
         pending_reg <= '0;
      end else begin
         pending_reg <= (pending_reg | bus.buttons) & ~clr;
         unique case (state_reg)
            IDLE: begin
               if (here_req) begin
                  state_reg <= DOOR_OPEN;
                  door_reg  <= 1'b1;
               end else if (up_cur && (dir_up_reg || !dn_cur)) begin
                  state_reg  <= MOVE_UP;
                  moving_reg <= 1'b1;
                  dir_up_reg <= 1'b1;
               end else if (dn_cur || park_go) begin
                  state_reg  <= MOVE_DOWN;
                  moving_reg <= 1'b1;
                  dir_up_reg <= 1'b0;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (tmr_zero) begin
                  floor_reg <= next_floor;
                  if (step_here_req) begin
                     state_reg  <= DOOR_OPEN;
                     moving_reg <= 1'b0;
                     door_reg   <= 1'b1;
                  end else if (!(ahead_nf || park_hold)) begin
                     if (behind_nf) begin
                        state_reg  <= (state_reg == MOVE_UP) ? MOVE_DOWN : MOVE_UP;
                        dir_up_reg <= !dir_up_reg;
                     end else begin
                        state_reg  <= IDLE;
                        moving_reg <= 1'b0;
                     end
                  end
               end
            end
            DOOR_OPEN: begin
               if (tmr_zero && !btn_here) begin
                  door_reg <= 1'b0;
                  if (dir_up_reg ? up_cur : dn_cur) begin
                     state_reg  <= dir_up_reg ? MOVE_UP : MOVE_DOWN;
                     moving_reg <= 1'b1;
                  end else if (dir_up_reg ? dn_cur : up_cur) begin
                     state_reg  <= dir_up_reg ? MOVE_DOWN : MOVE_UP;
                     moving_reg <= 1'b1;
                     dir_up_reg <= !dir_up_reg;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign bus.current_floor = floor_reg;
   assign bus.door_open     = door_reg;
   assign bus.moving        = moving_reg;
   assign bus.dir_up        = dir_up_reg;
   assign bus.pending       = pending_reg;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations, then random presses,
// every cycle compared against an elapsed-time behavioural model of the car.
module tb_elevator_scheduler;
   localparam int N      = 5;
   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;
`ifdef ELEV_PARK_EN
   localparam int PARK   = 16;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   elevator_scheduler_if bus_if ();

   elevator_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Model: mode 0 = idle, 1 = travelling, 2 = doors open.
   int         m_mode, m_pos, m_t, m_d;
   bit         m_up;
   logic [N-1:0] m_pend;
`ifdef ELEV_PARK_EN
   int         m_idle;
   bit         m_park;
`endif

   function automatic bit req_dir(logic [N-1:0] v, int pos, bit up);
      bit hit;
      hit = 0;
      for (int f = 0; f < N; f++) begin
         if (v[f] && (up ? (f > pos) : (f < pos))) hit = 1;
      end
      return hit;
   endfunction

   task automatic model_edge(input logic [N-1:0] b, input bit r);
      logic [N-1:0] old;
      int open;
      bit keep;
`ifdef ELEV_PARK_EN
      int idle_run;
`endif
      old  = m_pend;
      open = -1;
      keep = 0;
      if (r) begin
         m_mode = 0; m_pos = 0; m_up = 1; m_pend = '0; m_t = 0; m_d = 0;
`ifdef ELEV_PARK_EN
         m_idle = PARK; m_park = 0;
`endif
         return;
      end
`ifdef ELEV_PARK_EN
      idle_run = (m_mode == 0 && old == '0) ? ((m_idle < PARK) ? m_idle + 1 : PARK) : 0;
      m_idle   = idle_run;
`endif
      case (m_mode)
         0: begin
            if (old[m_pos]) begin
               m_mode = 2; m_d = 0; open = m_pos;
            end else if (req_dir(old, m_pos, 1) && (m_up || !req_dir(old, m_pos, 0))) begin
               m_mode = 1; m_up = 1; m_t = 0;
            end else if (req_dir(old, m_pos, 0)) begin
               m_mode = 1; m_up = 0; m_t = 0;
            end
`ifdef ELEV_PARK_EN
            else if (idle_run >= PARK && m_pos != 0) begin
               m_mode = 1; m_up = 0; m_t = 0; m_park = 1;
            end
`endif
         end
         1: begin
            m_t++;
            if (m_t == TRAVEL) begin
               m_pos += m_up ? 1 : -1;
`ifdef ELEV_PARK_EN
               keep   = m_park && old == '0 && m_pos != 0;
               m_park = keep;
`endif
               if (old[m_pos]) begin
                  m_mode = 2; m_d = 0; open = m_pos;
               end else if (req_dir(old, m_pos, m_up) || keep) begin
                  m_t = 0;
               end else if (req_dir(old, m_pos, !m_up)) begin
                  m_up = !m_up; m_t = 0;
               end else begin
                  m_mode = 0;
               end
            end
         end
         default: begin
            open = m_pos;
            if (b[m_pos]) begin
               m_d = 0;
            end else begin
               m_d++;
               if (m_d == DOOR) begin
                  if (req_dir(old, m_pos, m_up)) begin
                     m_mode = 1; m_t = 0;
                  end else if (req_dir(old, m_pos, !m_up)) begin
                     m_up = !m_up; m_mode = 1; m_t = 0;
                  end else begin
                     m_mode = 0;
                  end
               end
            end
         end
      endcase
      m_pend = old | b;
      if (open >= 0) m_pend[open] = 1'b0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic pin(input string name, input int dut_v, input int mod_v, input int lit);
      check({name, "_dut"}, dut_v, lit);
      check({name, "_model"}, mod_v, lit);
   endtask

   task automatic compare_model();
      check("floor", int'(bus_if.current_floor), m_pos);
      check("door_open", int'(bus_if.door_open), int'(m_mode == 2));
      check("moving", int'(bus_if.moving), int'(m_mode == 1));
      check("dir_up", int'(bus_if.dir_up), int'(m_up));
      check("pending", int'(bus_if.pending), int'(m_pend));
      check("door_and_moving", int'(bus_if.door_open && bus_if.moving), 0);
   endtask

   // Called at a negedge: drive, let the edge happen, advance the model, compare at next negedge.
   task automatic cycle(input logic [N-1:0] b, input bit r);
      bus_if.buttons = b;
      rst = r;
      @(posedge clk);
      model_edge(b, r);
      @(negedge clk);
      cyc++;
      compare_model();
   endtask

   initial begin
      logic [N-1:0] b;
      bit quiet;
      int len;
      bus_if.buttons = '0;
      rst = 1'b1;
      @(negedge clk);

      cycle('0, 1);
      pin("rst_floor", int'(bus_if.current_floor), m_pos, 0);
      pin("rst_dir", int'(bus_if.dir_up), int'(m_up), 1);
      pin("rst_pend", int'(bus_if.pending), int'(m_pend), 0);

      // Single press of floor 3 from floor 0.
      cycle(5'b01000, 0);
      pin("press_pend", int'(bus_if.pending), int'(m_pend), 8);
      pin("press_still", int'(bus_if.moving), int'(m_mode == 1), 0);
      cycle('0, 0);
      pin("depart", int'(bus_if.moving), int'(m_mode == 1), 1);
      repeat (4) cycle('0, 0);
      pin("floor1", int'(bus_if.current_floor), m_pos, 1);
      repeat (4) cycle('0, 0);
      pin("floor2", int'(bus_if.current_floor), m_pos, 2);
      repeat (4) cycle('0, 0);
      pin("floor3", int'(bus_if.current_floor), m_pos, 3);
      pin("arrive_door", int'(bus_if.door_open), int'(m_mode == 2), 1);
      pin("arrive_pend", int'(bus_if.pending), int'(m_pend), 0);
      repeat (2) cycle('0, 0);
      pin("dwell", int'(bus_if.door_open), int'(m_mode == 2), 1);
      cycle('0, 0);
      pin("door_close", int'(bus_if.door_open), int'(m_mode == 2), 0);

      // Re-open by holding the current floor's button.
      cycle(5'b01000, 0);
      cycle('0, 0);
      pin("reopen_door", int'(bus_if.door_open), int'(m_mode == 2), 1);
      repeat (5) cycle(5'b01000, 0);
      pin("hold_pend", int'(bus_if.pending), int'(m_pend), 0);
      repeat (2) cycle('0, 0);
      pin("hold_dwell", int'(bus_if.door_open), int'(m_mode == 2), 1);
      cycle('0, 0);
      pin("hold_close", int'(bus_if.door_open), int'(m_mode == 2), 0);

      // Reset while travelling down through floor 2.
      cycle(5'b00001, 0);
      cycle('0, 0);
      pin("down_dir", int'(bus_if.dir_up), int'(m_up), 0);
      repeat (4) cycle('0, 0);
      pin("mid_floor2", int'(bus_if.current_floor), m_pos, 2);
      cycle('0, 1);
      pin("midrst_floor", int'(bus_if.current_floor), m_pos, 0);
      pin("midrst_pend", int'(bus_if.pending), int'(m_pend), 0);
      pin("midrst_moving", int'(bus_if.moving), int'(m_mode == 1), 0);

      // Up to 4 with a late request for 1: stop at 4, reverse, stop at 1.
      cycle(5'b10000, 0);
      cycle('0, 0);
      repeat (4) cycle('0, 0);
      cycle(5'b10010, 0);
      repeat (11) cycle('0, 0);
      pin("top_floor", int'(bus_if.current_floor), m_pos, 4);
      pin("top_door", int'(bus_if.door_open), int'(m_mode == 2), 1);
      repeat (3) cycle('0, 0);
      pin("reverse_dir", int'(bus_if.dir_up), int'(m_up), 0);
      pin("reverse_moving", int'(bus_if.moving), int'(m_mode == 1), 1);
      repeat (12) cycle('0, 0);
      pin("stop1_floor", int'(bus_if.current_floor), m_pos, 1);
      pin("stop1_door", int'(bus_if.door_open), int'(m_mode == 2), 1);

      // Random traffic with quiet stretches long enough to idle (and park, when built).
      for (int seg = 0; seg < 100; seg++) begin
         quiet = ($urandom_range(0, 3) == 0);
         len   = quiet ? int'($urandom_range(20, 40)) : int'($urandom_range(10, 30));
         for (int k = 0; k < len; k++) begin
            b = '0;
            if (!quiet && $urandom_range(0, 5) == 0) b = 5'b00001 << $urandom_range(0, N - 1);
            cycle(b, ($urandom_range(0, 299) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
